// File: rtl/red_seq_ctrl.sv
// red_seq_ctrl: multi-cycle sequencer for the RED nibble-reduction operation.
// Captures two 16-bit operands, sums their eight nibbles LANES pairs per cycle
// through a narrow adder slice, and returns a 16-bit result with a done pulse.
// Build option: define RED_ZEXT_EN to zero-extend the 7-bit sum instead of
// sign-extending it from bit 6.
module red_seq_ctrl #(
    parameter int LANES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] SrcData1,
    input  logic [15:0] SrcData2,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] DesData
);

    // Number of ACC cycles needed to consume all four nibble pairs
    localparam int STEPS = (LANES > 0) ? (4 / LANES) : 1;
    // Operand shift per ACC cycle, in bits
    localparam int SHIFT = 4 * LANES;

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4) begin : g_bad_lanes
            $error("red_seq_ctrl: LANES must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] opa_q, opb_q;
    logic [6:0]  acc_q;
    logic [6:0]  acc_d;
    logic [6:0]  lane_sum;
    logic [1:0]  cnt_q;
    logic [15:0] des_q;
    logic [15:0] des_d;
    logic        accept;
    logic        last_step;

    // A request is taken only while the sequencer can accept (IDLE or DONE)
    assign accept    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_step = (cnt_q == 2'(STEPS - 1));
    assign DesData   = des_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> ACC on start, ACC -> DONE after STEPS cycles,
    // DONE -> ACC on a back-to-back start, else back to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = start ? S_ACC : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode: handshake outputs depend on state only
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            S_IDLE: begin
                ready = 1'b1;
            end
            S_ACC: begin
                busy = 1'b1;
            end
            S_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // Adder slice: sum of the lowest LANES unconsumed nibble pairs
    always_comb begin
        lane_sum = '0;
        for (int unsigned j = 0; j < LANES; j++) begin
            lane_sum = lane_sum + 7'(opa_q[4*j +: 4]) + 7'(opb_q[4*j +: 4]);
        end
        acc_d = acc_q + lane_sum;
    end

    // Result formatting of the final accumulator value
    always_comb begin
`ifdef RED_ZEXT_EN
        des_d = {9'b0, acc_d};
`else
        des_d = {{9{acc_d[6]}}, acc_d};
`endif
    end

    // Datapath: operand capture, shifting, accumulation and result register.
    // The result is written on the last ACC edge so it is valid in DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            opa_q <= '0;
            opb_q <= '0;
            acc_q <= '0;
            cnt_q <= '0;
            des_q <= '0;
        end else if (accept) begin
            opa_q <= SrcData1;
            opb_q <= SrcData2;
            acc_q <= '0;
            cnt_q <= '0;
        end else if (state_q == S_ACC) begin
            opa_q <= opa_q >> SHIFT;
            opb_q <= opb_q >> SHIFT;
            acc_q <= acc_d;
            cnt_q <= cnt_q + 2'd1;
            if (last_step) begin
                des_q <= des_d;
            end
        end
    end

    // Handshake sanity: never ready and busy together; done only when ready
    a_ready_busy_excl : assert property (@(posedge clk) disable iff (rst) !(ready && busy));
    a_done_ready      : assert property (@(posedge clk) disable iff (rst) done |-> ready);

endmodule

// File: tb/tb_red_seq_ctrl.sv
// Testbench for red_seq_ctrl: three instances (LANES = 1, 2, 4) share the
// stimulus; a cycle-level behavioural model is checked against every instance
// on every cycle, plus directed literal checks. Honours RED_ZEXT_EN.
module tb_red_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] src1 = '0;
    logic [15:0] src2 = '0;
    logic [2:0]  ready_w;
    logic [2:0]  busy_w;
    logic [2:0]  done_w;
    logic [15:0] des_w [3];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        red_seq_ctrl #(.LANES(1 << g)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .start    (start),
            .SrcData1 (src1),
            .SrcData2 (src2),
            .ready    (ready_w[g]),
            .busy     (busy_w[g]),
            .done     (done_w[g]),
            .DesData  (des_w[g])
        );
    end

    // Golden result: sum of all eight nibbles, formatted as a 7-bit count
    function automatic logic [15:0] gold(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) begin
            s = s + int'(a[4*i +: 4]) + int'(b[4*i +: 4]);
        end
`ifdef RED_ZEXT_EN
        return 16'(s);
`else
        return (s >= 64) ? 16'(s - 128) : 16'(s);
`endif
    endfunction

    // Model: an accepted op keeps the unit busy for 4/LANES cycles, then
    // shows done with the golden result for one cycle; result holds after.
    int          m_busy [3] = '{0, 0, 0};
    logic        m_done [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] m_des  [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] m_pend [3] = '{16'h0, 16'h0, 16'h0};

    always @(posedge clk or posedge rst) begin
        for (int k = 0; k < 3; k++) begin
            if (rst) begin
                m_busy[k] <= 0;
                m_done[k] <= 1'b0;
                m_des[k]  <= 16'h0;
            end else if (m_busy[k] == 0 && start) begin
                m_busy[k] <= 4 >> k;
                m_pend[k] <= gold(src1, src2);
                m_done[k] <= 1'b0;
            end else if (m_busy[k] > 0) begin
                m_busy[k] <= m_busy[k] - 1;
                m_done[k] <= (m_busy[k] == 1);
                if (m_busy[k] == 1) begin
                    m_des[k] <= m_pend[k];
                end
            end else begin
                m_done[k] <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("ready[L%0d]", 1 << k), 16'(ready_w[k]), 16'(m_busy[k] == 0));
                    chk($sformatf("busy[L%0d]", 1 << k), 16'(busy_w[k]), 16'(m_busy[k] != 0));
                    chk($sformatf("done[L%0d]", 1 << k), 16'(done_w[k]), 16'(m_done[k]));
                    chk($sformatf("DesData[L%0d]", 1 << k), des_w[k], m_des[k]);
                end
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s ready[L%0d]", tag, 1 << k), 16'(ready_w[k]), 16'h1);
            chk($sformatf("%s busy[L%0d]", tag, 1 << k), 16'(busy_w[k]), 16'h0);
            chk($sformatf("%s done[L%0d]", tag, 1 << k), 16'(done_w[k]), 16'h0);
            chk($sformatf("%s DesData[L%0d]", tag, 1 << k), des_w[k], 16'h0000);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ready_w != 3'b111 && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (ready_w != 3'b111) begin
            chk("wait_idle timeout", 16'(ready_w), 16'h7);
        end
    endtask

    // One-cycle start; returns latency (accept edge counts as cycle 1) and
    // the number of busy cycles seen on instance k before done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input int k,
                          output int lat, output int nbusy);
        @(negedge clk);
        start = 1'b1;
        src1  = a;
        src2  = b;
        @(negedge clk);
        start = 1'b0;
        src1  = ~a;
        src2  = ~b;
        lat   = 1;
        nbusy = 0;
        while (!done_w[k] && lat < 20) begin
            if (busy_w[k]) nbusy++;
            @(negedge clk);
            lat++;
        end
        if (!done_w[k]) begin
            chk("run_op done timeout", 16'(done_w[k]), 16'h1);
        end
    endtask

    initial begin
        int lat;
        int nb;
        int n;
        fork
            monitor();
        join_none

        // Asynchronous reset, checked before any clock edge
        #1 rst = 1'b1;
        #2 chk_reset_outputs("por");
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Basic op, LANES=1: 1+2+3+4 + 4*1 = 14
        run_op(16'h1234, 16'h1111, 0, lat, nb);
        chk("L1 latency", 16'(lat), 16'd5);
        chk("L1 busy cycles", 16'(nb), 16'd4);
        chk("L1 1234+1111", des_w[0], 16'h000E);
        wait_idle();

        // Maximum sum 120 = 0x78; bit 6 set, so sign-extension gives FFF8
        run_op(16'hFFFF, 16'hFFFF, 0, lat, nb);
`ifdef RED_ZEXT_EN
        chk("L1 FFFF+FFFF", des_w[0], 16'h0078);
`else
        chk("L1 FFFF+FFFF", des_w[0], 16'hFFF8);
`endif
        wait_idle();

        // Boundary 64 (first value with bit 6 set), LANES=2
        run_op(16'hFFFF, 16'h0004, 1, lat, nb);
        chk("L2 latency", 16'(lat), 16'd3);
`ifdef RED_ZEXT_EN
        chk("L2 sum 64", des_w[1], 16'h0040);
`else
        chk("L2 sum 64", des_w[1], 16'hFFC0);
`endif
        wait_idle();

        // Boundary 63, LANES=4
        run_op(16'hFFFF, 16'h0003, 2, lat, nb);
        chk("L4 latency", 16'(lat), 16'd2);
        chk("L4 sum 63", des_w[2], 16'h003F);
        wait_idle();

        // Start held through ACC and DONE; operands changed during ACC
        @(negedge clk);
        start = 1'b1;
        src1  = 16'h1234;
        src2  = 16'h1111;
        @(negedge clk);
        src1  = 16'hFFFF;
        src2  = 16'hFFFF;
        n = 0;
        while (!done_w[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b first done", 16'(done_w[0]), 16'h1);
        chk("b2b first DesData", des_w[0], 16'h000E);
        @(negedge clk);
        start = 1'b0;
        n = 1;
        while (!done_w[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b done spacing", 16'(n), 16'd5);
`ifdef RED_ZEXT_EN
        chk("b2b second DesData", des_w[0], 16'h0078);
`else
        chk("b2b second DesData", des_w[0], 16'hFFF8);
`endif
        wait_idle();

        // Reset in the 2nd ACC cycle abandons the op; outputs clear at once
        @(negedge clk);
        start = 1'b1;
        src1  = 16'h1234;
        src2  = 16'h5678;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("abort");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h0F0F, 16'h0000, 0, lat, nb);
        chk("post-abort latency", 16'(lat), 16'd5);
        chk("post-abort 0F0F+0000", des_w[0], 16'h001E);
        wait_idle();

        // Random sweep, start held for random spans with changing operands
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            start = 1'b1;
            src1  = 16'($urandom);
            src2  = 16'($urandom);
            repeat ($urandom_range(0, 2)) begin
                @(negedge clk);
                src1 = 16'($urandom);
                src2 = 16'($urandom);
            end
            @(negedge clk);
            start = 1'b0;
            repeat ($urandom_range(0, 4)) @(negedge clk);
        end
        wait_idle();
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
